// File: rtl/dac_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dac_ctrl_pkg
//
// Shared constants and types for the I2S audio DAC controller.
//
// Fixed timing relationships:
//   - One frame is 1024 system clocks.
//   - The left half-frame is followed by the right half-frame.
//   - Each half-frame is 32 bit slots of 16 clocks each.
//   - The DAC clocks are taken straight from bits of the frame counter:
//       MCLK = cnt[1], BCLK = cnt[3], LRCK = cnt[9].
//   - Slot index within a half-frame is cnt[8:4].
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package dac_ctrl_pkg;

    localparam int CNT_W    = 10;
    localparam int SAMPLE_W = 24;
    localparam int SLOT_W   = 5;

    // Frame counter bit positions that become the DAC clocks
    localparam int MCLK_BIT = 1;
    localparam int BCLK_BIT = 3;
    localparam int LRCK_BIT = 9;

    // Lowest counter bit of the slot index (slot = cnt[LRCK_BIT-1:SLOT_LSB])
    localparam int SLOT_LSB = BCLK_BIT + 1;

    // Slots that carry sample bits; everything else in a half-frame is zero
    localparam int DATA_SLOT_FIRST = 1;
    localparam int DATA_SLOT_LAST  = 24;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    // Which half of the frame is on the wire (matches the LRCK level)
    typedef enum logic {
        HALF_LEFT  = 1'b0,
        HALF_RIGHT = 1'b1
    } half_e;

    // One captured stereo sample pair
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;

    // Serial bit for a given slot of a half-frame.
    // Slot 0 is the one-BCLK I2S delay after the LRCK edge.
    // Slots 1..24 carry the word MSB first; the trailing slots are zero.
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word,
                                      input logic [SLOT_W-1:0]   slot);
        logic [SLOT_W-1:0] idx;
        logic              bit_val;
        bit_val = 1'b0;
        idx     = '0;
        if ((slot >= SLOT_W'(DATA_SLOT_FIRST)) && (slot <= SLOT_W'(DATA_SLOT_LAST))) begin
            idx     = SLOT_W'(DATA_SLOT_LAST) - slot;
            bit_val = word[idx];
        end
        return bit_val;
    endfunction

endpackage

// File: rtl/dac_ctrl_clkgen.sv
// ---------------------------------------------------------------------------
// dac_clkgen
//
// Free-running frame counter and everything derived from it.
//
// Ports:
//   clk            system clock (50 MHz), rising edge
//   rst            asynchronous active-low reset
//   mclk           DAC master clock, clk/4, 50% duty
//   bclk           DAC bit clock, clk/16, 50% duty
//   lrck           word clock, clk/1024 (0 = left, 1 = right)
//   next           one-cycle pulse in the cycle after the frame wrap
//   frame_wrap     high in the cycle whose closing edge wraps the counter 1023->0
//   bit_edge       high in the cycle whose closing edge is a BCLK falling edge
//   slot_upcoming  slot index that becomes current after the next edge
//   half_upcoming  half-frame that becomes current after the next edge
// ---------------------------------------------------------------------------
module dac_clkgen
    import dac_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic              mclk,
    output logic              bclk,
    output logic              lrck,
    output logic              next,
    output logic              frame_wrap,
    output logic              bit_edge,
    output logic [SLOT_W-1:0] slot_upcoming,
    output half_e             half_upcoming
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);

    // Frame counter. It simply wraps from 1023 to 0, so one frame is
    // exactly 1024 clocks and every derived clock has a 50% duty cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

    // Each DAC clock is a single register bit, so it cannot glitch.
    assign mclk = cnt[MCLK_BIT];
    assign bclk = cnt[BCLK_BIT];
    assign lrck = cnt[LRCK_BIT];

    // Strobes that look one edge ahead. The top level registers its serial
    // data on these strobes, so sdti lines up with the counter state that
    // appears after the same edge.
    assign frame_wrap    = (cnt == CNT_LAST);
    assign bit_edge      = (cnt[BCLK_BIT:0] == '1);
    assign slot_upcoming = cnt_inc[LRCK_BIT-1:SLOT_LSB];
    assign half_upcoming = half_e'(cnt_inc[LRCK_BIT]);

    // next is registered from the wrap strobe. It is therefore high while
    // cnt == 0, but only after a real wrap. The cnt == 0 cycle straight
    // out of reset does not raise it, so the first pulse comes a full
    // frame after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next <= 1'b0;
        end else begin
            next <= frame_wrap;
        end
    end

endmodule

// File: rtl/dac_ctrl.sv
// ---------------------------------------------------------------------------
// dac_ctrl
//
// I2S serial audio DAC controller. Captures one 24-bit stereo pair per
// frame (fs = 50 MHz / 1024) and sends it MSB first in I2S format.
//
// Ports:
//   clk       system clock (50 MHz), rising edge
//   rst       asynchronous active-low reset
//   sample_l  left sample, two's complement, sampled at the frame wrap
//   sample_r  right sample, two's complement, sampled at the frame wrap
//   next      one-cycle pulse: pair captured, source may present the next pair
//   mclk      DAC master clock, clk/4
//   bclk      DAC bit clock, clk/16
//   lrck      word clock, clk/1024 (0 = left half, 1 = right half)
//   sdti      serial data to the DAC, changes on BCLK falling edges
// ---------------------------------------------------------------------------
module dac_ctrl
    import dac_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    output logic                next,
    output logic                mclk,
    output logic                bclk,
    output logic                lrck,
    output logic                sdti
);

    logic              frame_wrap;
    logic              bit_edge;
    logic [SLOT_W-1:0] slot_upcoming;
    half_e             half_upcoming;
    sample_pair_t      hold;
    logic [SAMPLE_W-1:0] word_sel;
    logic              sdti_next;

    dac_clkgen u_clkgen (
        .clk           (clk),
        .rst           (rst),
        .mclk          (mclk),
        .bclk          (bclk),
        .lrck          (lrck),
        .next          (next),
        .frame_wrap    (frame_wrap),
        .bit_edge      (bit_edge),
        .slot_upcoming (slot_upcoming),
        .half_upcoming (half_upcoming)
    );

    // The sample pair is taken only on the wrap edge. Both halves of the
    // frame that starts on that edge are sent from this pair. The source
    // may change its inputs at any other time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else if (frame_wrap) begin
            hold.left  <= sample_l;
            hold.right <= sample_r;
        end
    end

    // Choose the bit for the slot that starts after the next edge.
    // On the wrap edge the upcoming slot is slot 0, which is always zero.
    // So the stale pair still in hold never reaches the wire, even though
    // hold is being reloaded on that same edge.
    always_comb begin
        word_sel = hold.left;
        if (half_upcoming == HALF_RIGHT) begin
            word_sel = hold.right;
        end
        sdti_next = slot_bit(word_sel, slot_upcoming);
    end

    // sdti is a register that loads only on BCLK falling edges. Each slot
    // value is therefore held for 16 clocks and is settled well before the
    // BCLK rising edge that the DAC uses to sample it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdti <= 1'b0;
        end else if (bit_edge) begin
            sdti <= sdti_next;
        end
    end

endmodule

// File: tb/tb_dac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dac_ctrl
//
// Self-checking bench for dac_ctrl. A reference model follows the frame
// rules arithmetically from the number of clock edges since reset release.
// ---------------------------------------------------------------------------
module tb_dac_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] sample_l = '0;
    logic [23:0] sample_r = '0;
    logic        next, mclk, bclk, lrck, sdti;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #10 clk = ~clk;

    dac_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .sample_l (sample_l),
        .sample_r (sample_r),
        .next     (next),
        .mclk     (mclk),
        .bclk     (bclk),
        .lrck     (lrck),
        .sdti     (sdti)
    );

    // Reference model state.
    //   t     = rising edges since reset release.
    //   cap_* = pair captured for the frame that contains t.
    // The pair is captured on every edge where t reaches a multiple of 1024.
    int unsigned t = 0;
    logic [23:0] cap_l = '0;
    logic [23:0] cap_r = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t     <= 0;
            cap_l <= '0;
            cap_r <= '0;
        end else begin
            if ((t % 1024) == 1023) begin
                cap_l <= sample_l;
                cap_r <= sample_r;
            end
            t <= t + 1;
        end
    end

    function automatic logic m_mclk(int unsigned tt);
        return (((tt % 1024) / 2) % 2) == 1;
    endfunction

    function automatic logic m_bclk(int unsigned tt);
        return (((tt % 1024) / 8) % 2) == 1;
    endfunction

    function automatic logic m_lrck(int unsigned tt);
        return (tt % 1024) >= 512;
    endfunction

    function automatic logic m_next(int unsigned tt);
        return (tt >= 1024) && ((tt % 1024) == 0);
    endfunction

    function automatic logic m_sdti(int unsigned tt, logic [23:0] l, logic [23:0] r);
        int unsigned p;
        int unsigned slot;
        logic [23:0] w;
        p    = tt % 1024;
        slot = (p % 512) / 16;
        w    = (p < 512) ? l : r;
        if (slot < 1 || slot > 24) return 1'b0;
        return w[24 - slot];
    endfunction

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst      = 1'b0;
        sample_l = 24'h0FF0F6;
        sample_r = 24'hAA55A6;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++;
            if ({next, mclk, bclk, lrck, sdti} !== 5'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs got %b expected 00000", {next, mclk, bclk, lrck, sdti});
            end
        end
        #5;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // First frame: clock waveforms and an all-zero data stream
    task automatic test_first_frame();
        int mclk_rise = 0, bclk_rise = 0, lrck_rise = 0;
        int mclk_high = 0, bclk_high = 0, lrck_high = 0;
        logic pm = 1'b0, pb = 1'b0, pl = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            n_checks += 5;
            if (mclk !== m_mclk(t)) begin
                n_fail++;
                $display("[TB] FAIL first_mclk t=%0d got %b expected %b", t, mclk, m_mclk(t));
            end
            if (bclk !== m_bclk(t)) begin
                n_fail++;
                $display("[TB] FAIL first_bclk t=%0d got %b expected %b", t, bclk, m_bclk(t));
            end
            if (lrck !== m_lrck(t)) begin
                n_fail++;
                $display("[TB] FAIL first_lrck t=%0d got %b expected %b", t, lrck, m_lrck(t));
            end
            if (sdti !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL first_sdti_zero t=%0d got %b expected 0", t, sdti);
            end
            if (next !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL first_next t=%0d got %b expected 0", t, next);
            end
            if (mclk && !pm) mclk_rise++;
            if (bclk && !pb) bclk_rise++;
            if (lrck && !pl) lrck_rise++;
            if (mclk) mclk_high++;
            if (bclk) bclk_high++;
            if (lrck) lrck_high++;
            pm = mclk; pb = bclk; pl = lrck;
            @(negedge clk);
        end
        n_checks += 6;
        if (mclk_rise != 256) begin
            n_fail++;
            $display("[TB] FAIL mclk_period rises=%0d expected 256", mclk_rise);
        end
        if (bclk_rise != 64) begin
            n_fail++;
            $display("[TB] FAIL bclk_period rises=%0d expected 64", bclk_rise);
        end
        if (lrck_rise != 1) begin
            n_fail++;
            $display("[TB] FAIL lrck_period rises=%0d expected 1", lrck_rise);
        end
        if (mclk_high != 512) begin
            n_fail++;
            $display("[TB] FAIL mclk_duty high=%0d expected 512", mclk_high);
        end
        if (bclk_high != 512) begin
            n_fail++;
            $display("[TB] FAIL bclk_duty high=%0d expected 512", bclk_high);
        end
        if (lrck_high != 512) begin
            n_fail++;
            $display("[TB] FAIL lrck_duty high=%0d expected 512", lrck_high);
        end
    endtask

    // Second frame, left half: first next pulse and the left data word
    task automatic test_left_data();
        logic [31:0] word = '0;
        logic [31:0] exp_word = {1'b0, 24'h0FF0F6, 7'b0};
        n_checks += 2;
        if (next !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL first_next_pulse t=%0d got %b expected 1", t, next);
        end
        if (lrck !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lrck_fall_at_next t=%0d got %b expected 0", t, lrck);
        end
        for (int i = 0; i < 512; i++) begin
            if ((t % 16) == 8) word[31 - ((t % 512) / 16)] = sdti;
            n_checks += 2;
            if (sdti !== m_sdti(t, cap_l, cap_r)) begin
                n_fail++;
                $display("[TB] FAIL left_sdti t=%0d got %b expected %b", t, sdti, m_sdti(t, cap_l, cap_r));
            end
            if (next !== m_next(t)) begin
                n_fail++;
                $display("[TB] FAIL left_next t=%0d got %b expected %b", t, next, m_next(t));
            end
            @(negedge clk);
        end
        n_checks++;
        if (word !== exp_word) begin
            n_fail++;
            $display("[TB] FAIL left_word got %h expected %h", word, exp_word);
        end
    endtask

    // Second frame, right half: the right data word
    task automatic test_right_data();
        logic [31:0] word = '0;
        logic [31:0] exp_word = {1'b0, 24'hAA55A6, 7'b0};
        for (int i = 0; i < 512; i++) begin
            if ((t % 16) == 8) word[31 - ((t % 512) / 16)] = sdti;
            n_checks += 2;
            if (sdti !== m_sdti(t, cap_l, cap_r)) begin
                n_fail++;
                $display("[TB] FAIL right_sdti t=%0d got %b expected %b", t, sdti, m_sdti(t, cap_l, cap_r));
            end
            if (lrck !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL right_lrck t=%0d got %b expected 1", t, lrck);
            end
            @(negedge clk);
        end
        n_checks += 3;
        if (word !== exp_word) begin
            n_fail++;
            $display("[TB] FAIL right_word got %h expected %h", word, exp_word);
        end
        if (word[30] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL right_slot1 got %b expected 1", word[30]);
        end
        if (word[7] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL right_slot24 got %b expected 0", word[7]);
        end
    endtask

    // Two further frames: next pulses once per 1024 clocks, nothing else
    task automatic test_next_cadence();
        int unsigned pulses[$];
        for (int i = 0; i < 2048; i++) begin
            if (next === 1'b1) pulses.push_back(t);
            n_checks++;
            if (next !== m_next(t)) begin
                n_fail++;
                $display("[TB] FAIL cadence_next t=%0d got %b expected %b", t, next, m_next(t));
            end
            @(negedge clk);
        end
        n_checks++;
        if (pulses.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL cadence_count got %0d expected 2", pulses.size());
        end else begin
            n_checks++;
            if (pulses[1] - pulses[0] != 1024) begin
                n_fail++;
                $display("[TB] FAIL cadence_interval got %0d expected 1024", pulses[1] - pulses[0]);
            end
        end
    endtask

    // Change sample_l mid-frame: only the following frame may show it
    task automatic test_capture_point();
        logic [23:0] old_l = sample_l;
        logic [23:0] new_l;
        logic [31:0] word;
        for (int i = 0; i < 1024 && (t % 1024) != 0; i++) @(negedge clk);
        n_checks++;
        if ((t % 1024) != 0) begin
            n_fail++;
            $display("[TB] FAIL capture_align t=%0d expected frame start", t);
        end
        new_l = 24'($urandom);
        if (new_l == old_l) new_l = ~old_l;
        for (int f = 0; f < 2; f++) begin
            word = '0;
            for (int i = 0; i < 1024; i++) begin
                if (f == 0 && (t % 1024) == 500) sample_l = new_l;
                if ((t % 1024) < 512 && (t % 16) == 8) word[31 - ((t % 512) / 16)] = sdti;
                n_checks++;
                if (sdti !== m_sdti(t, cap_l, cap_r)) begin
                    n_fail++;
                    $display("[TB] FAIL capture_sdti t=%0d got %b expected %b", t, sdti, m_sdti(t, cap_l, cap_r));
                end
                @(negedge clk);
            end
            n_checks++;
            if (word !== {1'b0, (f == 0) ? old_l : new_l, 7'b0}) begin
                n_fail++;
                $display("[TB] FAIL capture_word frame=%0d got %h expected %h", f, word, {1'b0, (f == 0) ? old_l : new_l, 7'b0});
            end
        end
    endtask

    // Random pairs changed at random points in each frame
    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            int unsigned chg = $urandom_range(1023, 0);
            for (int i = 0; i < 1024; i++) begin
                if (i == chg) begin
                    sample_l = 24'($urandom);
                    sample_r = 24'($urandom);
                end
                n_checks += 3;
                if (sdti !== m_sdti(t, cap_l, cap_r)) begin
                    n_fail++;
                    $display("[TB] FAIL random_sdti t=%0d got %b expected %b", t, sdti, m_sdti(t, cap_l, cap_r));
                end
                if (next !== m_next(t)) begin
                    n_fail++;
                    $display("[TB] FAIL random_next t=%0d got %b expected %b", t, next, m_next(t));
                end
                if (lrck !== m_lrck(t)) begin
                    n_fail++;
                    $display("[TB] FAIL random_lrck t=%0d got %b expected %b", t, lrck, m_lrck(t));
                end
                @(negedge clk);
            end
        end
    endtask

    // Reset asserted in the right half-frame, then a clean restart
    task automatic test_mid_reset();
        int unsigned first_next = 0;
        sample_l = 24'hFFFFFF;
        sample_r = 24'h800001;
        for (int i = 0; i < 2048 && (t % 1024) != 700; i++) @(negedge clk);
        n_checks++;
        if ((t % 1024) != 700) begin
            n_fail++;
            $display("[TB] FAIL midreset_align t=%0d expected phase 700", t);
        end
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({next, mclk, bclk, lrck, sdti} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_immediate got %b expected 00000", {next, mclk, bclk, lrck, sdti});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({next, mclk, bclk, lrck, sdti} !== 5'b0) begin
                n_fail++;
                $display("[TB] FAIL midreset_held got %b expected 00000", {next, mclk, bclk, lrck, sdti});
            end
        end
        rst = 1'b1;
        for (int i = 0; i <= 1024; i++) begin
            if (next === 1'b1 && first_next == 0) first_next = t;
            n_checks += 3;
            if (t < 1024 && sdti !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midreset_zero_frame t=%0d got %b expected 0", t, sdti);
            end
            if (next !== m_next(t)) begin
                n_fail++;
                $display("[TB] FAIL midreset_next t=%0d got %b expected %b", t, next, m_next(t));
            end
            if (mclk !== m_mclk(t)) begin
                n_fail++;
                $display("[TB] FAIL midreset_mclk t=%0d got %b expected %b", t, mclk, m_mclk(t));
            end
            if (i < 1024) @(negedge clk);
        end
        n_checks++;
        if (first_next != 1024) begin
            n_fail++;
            $display("[TB] FAIL midreset_first_next got %0d expected 1024", first_next);
        end
    endtask

    initial begin
        $display("[TB] dac_ctrl bench start");
        test_reset();
        test_first_frame();
        test_left_data();
        test_right_data();
        test_next_cadence();
        test_capture_point();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_ctrl.md
Name: dac_ctrl

Overview:
- Serial audio DAC controller. Runs from the 50 MHz system clock.
- Takes one 24-bit stereo sample pair per frame and requests the next pair with a one-cycle `next` pulse.
- Generates master, bit and word clocks, plus I2S-format serial data, for an external 24-bit audio DAC.
- fs = 50 MHz / 1024 ≈ 48.83 kHz.

Parameters:
- none: all ratios are fixed (MCLK = clk/4 = 256·fs, BCLK = clk/16 = 64·fs, LRCK = clk/1024 = fs, 24-bit samples).

Ports:
- clk  input  1  system clock, 50 MHz, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- sample_l  input  24  left sample, two's complement, MSB first on the wire
- sample_r  input  24  right sample, two's complement
- next  output  1  one-cycle pulse: sample pair captured, source may present the next pair
- mclk  output  1  DAC master clock, clk/4, 50% duty
- bclk  output  1  DAC bit clock, clk/16, 50% duty
- lrck  output  1  word clock, clk/1024; 0 = left half-frame, 1 = right half-frame
- sdti  output  1  serial data to DAC

Behaviour:
- Frame counter
  - Free-running 10-bit counter `cnt`, increments every clk and wraps 1023→0.
  - Outputs derive from it: mclk = cnt[1], bclk = cnt[3], lrck = cnt[9].
  - Slot index = cnt[8:4] (0..31) within each half-frame.
- Sample capture
  - On the clk edge where cnt wraps 1023→0, hold_l <= sample_l and hold_r <= sample_r.
  - Inputs are sampled only at that edge; they may change freely at any other time.
- next
  - High exactly during the cycle with cnt == 0, i.e. the cycle after capture.
  - Period 1024 clk. The source has 1023 cycles to set up the next pair.
- Data format (I2S)
  - Per half-frame: slot 0 = 0 (one-BCLK delay after the LRCK edge).
  - Slots 1..24 = hold bits 23..0, MSB first.
  - Slots 25..31 = 0.
  - Left half uses hold_l, right half uses hold_r, both from the capture at the start of the same frame.
- sdti timing
  - Registered, no glitches.
  - Changes only at bclk falling edges (the edge where cnt[3:0] becomes 0).
  - Holds one slot value for 16 clk; stable around every bclk rising edge (cnt[3:0] 7→8).
- Reset (rst = 0, asynchronous)
  - cnt = 0; hold_l = hold_r = 0.
  - next = mclk = bclk = lrck = sdti = 0.
- After reset release
  - The first frame transmits zeros.
  - The first capture and the first next pulse occur 1024 clk after release.
- Reset asserted mid-frame: all state clears immediately, with no partial-frame completion.
- Constant inputs are transmitted identically every frame.

Decomposition:
- Shared package with constants:
  - CNT_W = 10, SAMPLE_W = 24
  - counter bit indices for MCLK (1), BCLK (3), LRCK (9)
  - DATA_SLOT_FIRST = 1, DATA_SLOT_LAST = 24
- One sub-module is natural: dac_clkgen (counter plus mclk/bclk/lrck/slot/next-strobe generation).
- Top level holds the capture registers and the sdti slot multiplexer/shift logic.

Test Plan:
- Reset: rst = 0 for 145 ns, then release synchronously → all outputs 0 during reset; mclk period 80 ns, bclk period 320 ns, lrck period 20.48 µs, all 50% duty.
- next cadence: after release, next pulses exactly one cycle every 1024 clk → first pulse 1024 clk after release, coincident with the lrck 1→0 edge.
- Left data: sample_l = 0x0FF0F6 held constant → in the second frame, slots 1..24 of the left half sampled on bclk rising give bits 0000_1111_1111_0000_1111_0110; slots 0 and 25..31 are 0.
- Right data: sample_r = 0xAA55A6 held constant → right-half slots 1..24 = 1010_1010_0101_0101_1010_0110; slot 1 = 1, slot 24 = 0.
- Capture point: change sample_l at cnt = 500 of a frame → the current frame is unaffected; the new value appears in the next frame only.
- Mid-frame reset: assert rst during the right half-frame → outputs go to 0 immediately; after release, first frame is all zeros and next follows 1024 clk later.
